// File: rtl/logic_sched_pkg.sv
// rtl/logic_sched_pkg.sv - opcode encodings and bitwise evaluation function for logic_op_scheduler
//
// Purpose: shared definitions for the logic-op scheduler and its reference model.
// Contents:
//   OP_*       3-bit opcode encodings
//   EVAL_W     width the evaluation function works at; callers truncate to their own width
//   logic_eval bitwise evaluation of (a, b, op)
package logic_sched_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOTA = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  // All ops are bitwise, so evaluating at a wide fixed width and truncating
  // afterwards gives the same result as evaluating at the narrow width.
  localparam int EVAL_W = 32;

  function automatic logic [EVAL_W-1:0] logic_eval(
    input logic [EVAL_W-1:0] a,
    input logic [EVAL_W-1:0] b,
    input logic [2:0]        op
  );
    logic [EVAL_W-1:0] y;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_NOTA: y = ~a;
      default: y = a;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter searching upward from a pointer
//
// Purpose: picks the first asserted request at or above ptr, wrapping modulo NUM_REQ.
// Ports:
//   req      in   NUM_REQ  request vector
//   ptr      in   ID_W     highest-priority index (always < NUM_REQ)
//   en       in   1        grant allowed this cycle
//   grant    out  NUM_REQ  one-hot grant, zero when en is low or no request
//   grant_id out  ID_W     encoded index of grant (0 when none)
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  logic [ID_W:0]   idx_wide;
  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx_wide = '0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_wide = {1'b0, ptr} + (ID_W+1)'(k);
      if (idx_wide >= (ID_W+1)'(NUM_REQ)) begin
        idx_wide = idx_wide - (ID_W+1)'(NUM_REQ);
      end
      idx = idx_wide[ID_W-1:0];
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/logic_op_scheduler.sv
// rtl/logic_op_scheduler.sv - round-robin shared registered bitwise logic unit (optional stats: LOGIC_SCHED_STATS_EN)
//
// Purpose: serialises NUM_REQ requesters onto one registered logic unit; results
// come back one cycle after accept, tagged with the requester id.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_ready per-requester handshake (req_ready one-hot or zero)
//   req_a, req_b        packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_op              packed opcodes, requester i at [i*3 +: 3]
//   rsp_valid/rsp_ready response handshake
//   rsp_y, rsp_id       result and originating requester id
//   busy                response pending or any request valid
//   op_count            (LOGIC_SCHED_STATS_EN) saturating accepted-request count
//   starve_flag         (LOGIC_SCHED_STATS_EN) sticky starvation indicator
module logic_op_scheduler
  import logic_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 5,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]     req_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_y,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy
`ifdef LOGIC_SCHED_STATS_EN
  ,
  output logic [15:0]              op_count,
  output logic                     starve_flag
`endif
);

  logic [ID_W-1:0]    ptr;
  logic               slot_free;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               fire;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;
  logic [2:0]         op_sel;
  logic [WIDTH-1:0]   y_next;
  logic [ID_W-1:0]    ptr_next;

  // The single output register may be refilled in the same cycle it drains.
  assign slot_free = !rsp_valid || rsp_ready;

  // Gating with rst keeps req_ready low while reset is held.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req      (req_valid),
    .ptr      (ptr),
    .en       (slot_free && !rst),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_ready = grant;
  // The arbiter only grants asserted requests, so any grant is a transfer.
  assign fire      = |grant;
  assign busy      = rsp_valid || (|req_valid);

  assign a_sel  = req_a[int'(grant_id)*WIDTH +: WIDTH];
  assign b_sel  = req_b[int'(grant_id)*WIDTH +: WIDTH];
  assign op_sel = req_op[int'(grant_id)*3 +: 3];
  assign y_next = WIDTH'(logic_eval(EVAL_W'(a_sel), EVAL_W'(b_sel), op_sel));

  assign ptr_next = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_id    <= '0;
      ptr       <= '0;
    end else if (fire) begin
      rsp_valid <= 1'b1;
      rsp_y     <= y_next;
      rsp_id    <= grant_id;
      ptr       <= ptr_next;
    end else if (rsp_ready) begin
      // Drain only; result and id are left as they were.
      rsp_valid <= 1'b0;
    end
  end

`ifdef LOGIC_SCHED_STATS_EN
  localparam int WAIT_W = $clog2(2*NUM_REQ+2);

  logic [NUM_REQ-1:0][WAIT_W-1:0] wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count    <= '0;
      starve_flag <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      if (fire && (op_count != 16'hFFFF)) begin
        op_count <= op_count + 16'd1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && !grant[i]) begin
          if (wait_cnt[i] != '1) begin
            wait_cnt[i] <= wait_cnt[i] + WAIT_W'(1);
          end
          // This cycle is wait number wait_cnt+1; flag once it exceeds 2*NUM_REQ.
          if (wait_cnt[i] >= WAIT_W'(2*NUM_REQ)) begin
            starve_flag <= 1'b1;
          end
        end else begin
          wait_cnt[i] <= '0;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_logic_op_scheduler.sv
// tb/tb_logic_op_scheduler.sv - scoreboard testbench for logic_op_scheduler
module tb_logic_op_scheduler;
  import logic_sched_pkg::*;

  localparam int N  = 4;
  localparam int W  = 5;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*3-1:0] req_op;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_y;
  logic [IW-1:0]  rsp_id;
  logic           busy;
`ifdef LOGIC_SCHED_STATS_EN
  logic [15:0]    op_count;
  logic           starve_flag;
`endif

  logic_op_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id),
    .busy      (busy)
`ifdef LOGIC_SCHED_STATS_EN
    ,
    .op_count    (op_count),
    .starve_flag (starve_flag)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [IW+W-1:0] sb[$];

  // Per-requester directed operands and their hand-computed results.
  logic [W-1:0] ta [N];
  logic [W-1:0] tb [N];
  logic [2:0]   to [N];
  logic [W-1:0] ty [N];
  logic [W-1:0] sweep_y [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_op[i*3 +: 3] = op;
  endtask

  task automatic push(input logic [IW-1:0] id, input logic [W-1:0] y);
    sb.push_back({id, y});
  endtask

  // Monitor: samples 1 time unit before each rising edge, when a response handshake is about to happen.
  initial begin
    logic [IW+W-1:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got id=%0d y=%b expected no response", rsp_id, rsp_y);
        end else begin
          e = sb.pop_front();
          check("rsp_id_y", {rsp_id, rsp_y}, e);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ta[0] = 5'b00011; tb[0] = 5'b00101; to[0] = OP_AND;  ty[0] = 5'b00001;
    ta[1] = 5'b01010; tb[1] = 5'b00110; to[1] = OP_OR;   ty[1] = 5'b01110;
    ta[2] = 5'b10110; tb[2] = 5'b01100; to[2] = OP_XOR;  ty[2] = 5'b11010;
    ta[3] = 5'b11111; tb[3] = 5'b10001; to[3] = OP_NOR;  ty[3] = 5'b00000;
    sweep_y[0] = 5'b10001; sweep_y[1] = 5'b11101; sweep_y[2] = 5'b01100; sweep_y[3] = 5'b01110;
    sweep_y[4] = 5'b00010; sweep_y[5] = 5'b10011; sweep_y[6] = 5'b00110; sweep_y[7] = 5'b11001;

    rst = 1'b1; rsp_ready = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
    for (int i = 0; i < N; i++) set_req(i, ta[i], tb[i], to[i]);

    // Reset / idle
    repeat (2) @(negedge clk);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_y", rsp_y, 5'b0);
    check("reset_rsp_id", rsp_id, 2'd0);
    check("reset_busy", busy, 1'b0);
    check("reset_req_ready", req_ready, 4'b0000);
    req_valid = 4'b0001;
    #1;
    check("reset_req_ready_masked", req_ready, 4'b0000);
    check("reset_busy_valid", busy, 1'b1);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    // Round robin: all valid, then requester 1 drops out
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_all_ready", req_ready, 4'b0001 << (k % 4));
      push(IW'(k % 4), ty[k % 4]);
      @(negedge clk);
    end
    req_valid = 4'b1101;
    for (int k = 0; k < 4; k++) begin
      int id;
      id = (k == 0 || k == 3) ? 2 : (k == 1 ? 3 : 0);
      #1;
      check("rr_skip1_ready", req_ready, 4'b0001 << id);
      push(IW'(id), ty[id]);
      @(negedge clk);
    end
    req_valid = '0;
    @(negedge clk);

    // Single op from requester 2 (pointer now at 3)
    req_valid = 4'b0100;
    #1;
    check("single_ready", req_ready, 4'b0100);
    push(2'd2, 5'b11010);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);

    // Backpressure: pointer at 3, requester 0 wins, then hold 3 cycles
    req_valid = 4'b0001;
    #1;
    check("bp_first_ready", req_ready, 4'b0001);
    push(2'd0, ty[0]);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ready_low", req_ready, 4'b0000);
      check("bp_valid_hold", rsp_valid, 1'b1);
      check("bp_y_hold", rsp_y, ty[0]);
      check("bp_id_hold", rsp_id, 2'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_grant", req_ready, 4'b0010);
    push(2'd1, ty[1]);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);

    // Opcode sweep on requester 0, back to back
    req_valid = 4'b0001;
    for (int op = 0; op < 8; op++) begin
      set_req(0, 5'b11001, 5'b10101, 3'(op));
      #1;
      check("sweep_ready", req_ready, 4'b0001);
      push(2'd0, sweep_y[op]);
      @(negedge clk);
    end
    req_valid = '0;
    @(negedge clk);
    #1;
    check("drain_valid", rsp_valid, 1'b0);
    check("drain_y_hold", rsp_y, 5'b11001);
    check("drain_id_hold", rsp_id, 2'd0);
    check("drain_busy", busy, 1'b0);
    @(negedge clk);

    // Async reset while a response is pending (pointer at 1)
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    #1;
    check("ar_grant", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("ar_pending", rsp_valid, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("ar_valid_dropped", rsp_valid, 1'b0);
    check("ar_y_cleared", rsp_y, 5'b0);
    check("ar_id_cleared", rsp_id, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    set_req(0, ta[0], tb[0], to[0]);
    req_valid = 4'b1111;
    #1;
    check("ar_first_grant", req_ready, 4'b0001);
    push(2'd0, ty[0]);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);

`ifdef LOGIC_SCHED_STATS_EN
    set_req(0, 5'b10101, 5'b00000, OP_PASS);
    req_valid = 4'b0001;
    for (int k = 0; k < 70000; k++) begin
      push(2'd0, 5'b10101);
      @(negedge clk);
    end
    req_valid = '0;
    repeat (3) @(negedge clk);
    check("stats_op_count_sat", op_count, 16'hFFFF);
    check("stats_no_starve", starve_flag, 1'b0);
`endif

    check("sb_empty", sb.size(), 0);
    check("end_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
